result_buffer: RTL and testbench

// - Downstream of the calculator adder: packs consecutive DATA_W-bit sums into MEM_WORD_SIZE-bit

---
 rtl/calculator_pkg.sv | 17 +
 rtl/result_buffer.sv | 118 +++++++++++
 tb/tb_result_buffer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/calculator_pkg.sv
// Shared widths and state encoding for the calculator datapath.
package calculator_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned MEM_WORD_SIZE = 64;
  localparam int unsigned ADDR_W        = 9;
  localparam int unsigned HALF_W        = MEM_WORD_SIZE / 2;

  typedef enum logic [2:0] {
    BUF_IDLE,
    BUF_LO,
    BUF_HI,
    BUF_WR,
    BUF_DONE
  } buf_state_t;

endpackage

// File: rtl/result_buffer.sv
// Packs pairs of adder sums into SRAM words and writes them across a line range.
module result_buffer
  import calculator_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        start_addr_i,
  input  logic [ADDR_W-1:0]        end_addr_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  input  logic [DATA_W-1:0]        in_data_i,
  output logic                     in_ready_o,
  output logic                     wr_en_o,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic [MEM_WORD_SIZE-1:0] wr_data_o,
  input  logic                     mem_gnt_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ADDR_W:0]          words_o
);

  if (HALF_W != DATA_W) begin : g_width_check
    $error("result_buffer: MEM_WORD_SIZE must be twice DATA_W");
  end

  buf_state_t               state_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [ADDR_W-1:0]        last_q;
  logic [MEM_WORD_SIZE-1:0] data_q;
  logic [ADDR_W:0]          words_q;
  logic                     finish_q;
  logic                     beat;

  assign beat = in_valid_i && in_ready_o;

  // All outputs decode directly from registered state, so they are glitch-free.
  assign in_ready_o = (state_q == BUF_LO) || (state_q == BUF_HI);
  assign wr_en_o    = (state_q == BUF_WR);
  assign busy_o     = (state_q != BUF_IDLE);
  assign done_o     = (state_q == BUF_DONE);
  assign wr_addr_o  = addr_q;
  assign wr_data_o  = data_q;
  assign words_o    = words_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= BUF_IDLE;
      addr_q   <= '0;
      last_q   <= '0;
      data_q   <= '0;
      words_q  <= '0;
      finish_q <= 1'b0;
    end else begin
      unique case (state_q)
        BUF_IDLE: begin
          if (start_i) begin
            addr_q   <= start_addr_i;
            last_q   <= end_addr_i;
            words_q  <= '0;
            finish_q <= 1'b0;
            state_q  <= BUF_LO;
          end
        end
        BUF_LO: begin
          if (beat) begin
            // Upper half cleared here so a flush sealing this beat writes zeros above it.
            data_q <= {HALF_W'(0), in_data_i};
            if (flush_i) begin
              finish_q <= 1'b1;
              state_q  <= BUF_WR;
            end else begin
              state_q  <= BUF_HI;
            end
          end else if (flush_i) begin
            state_q <= BUF_DONE;
          end
        end
        BUF_HI: begin
          if (beat) begin
            data_q[MEM_WORD_SIZE-1:HALF_W] <= in_data_i;
            finish_q <= flush_i;
            state_q  <= BUF_WR;
          end else if (flush_i) begin
            data_q[MEM_WORD_SIZE-1:HALF_W] <= '0;
            finish_q <= 1'b1;
            state_q  <= BUF_WR;
          end
        end
        BUF_WR: begin
          if (mem_gnt_i) begin
            words_q <= words_q + (ADDR_W + 1)'(1);
            if (finish_q || (addr_q == last_q)) begin
              state_q <= BUF_DONE;
            end else begin
              addr_q  <= addr_q + ADDR_W'(1);
              state_q <= BUF_LO;
            end
          end
        end
        BUF_DONE: begin
          state_q <= BUF_IDLE;
        end
        default: begin
          state_q <= BUF_IDLE;
        end
      endcase
    end
  end

  // A pending write must not change under the arbiter's feet.
  a_wr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (wr_en_o && !mem_gnt_i) |=> (wr_en_o && $stable(wr_addr_o) && $stable(wr_data_o)));

  a_ready_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(in_ready_o && wr_en_o));

endmodule

// File: tb/tb_result_buffer.sv
// Self-checking bench for result_buffer: directed table, corner sequences, randomized runs.
module tb_result_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [8:0]  start_addr_i = '0;
  logic [8:0]  end_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_data_i = '0;
  logic        in_ready_o;
  logic        wr_en_o;
  logic [8:0]  wr_addr_o;
  logic [63:0] wr_data_o;
  logic        mem_gnt_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [9:0]  words_o;

  result_buffer dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .start_addr_i(start_addr_i),
    .end_addr_i  (end_addr_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .mem_gnt_i   (mem_gnt_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .words_o     (words_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  logic [72:0] wq[$];     // observed writes {addr, data}
  logic [72:0] exp_q[$];  // expected writes
  logic [31:0] beats[16];

  always @(posedge clk_i) begin
    if (rst_ni && wr_en_o && mem_gnt_i) wq.push_back({wr_addr_o, wr_data_o});
    if (rst_ni && done_o) done_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference: sums pair up in arrival order, odd tail padded with zero, lines advance mod 512.
  task automatic build_exp(input logic [8:0] sa, input int n);
    logic [31:0] hi;
    logic [8:0]  a;
    exp_q.delete();
    for (int i = 0; 2 * i < n; i++) begin
      hi = (2 * i + 1 < n) ? beats[2 * i + 1] : 32'd0;
      a  = 9'((int'(sa) + i) % 512);
      exp_q.push_back({a, hi, beats[2 * i]});
    end
  endtask

  // fm: 0 = no flush, 1 = flush after the last beat, 2 = flush together with the last beat.
  task automatic do_run(input logic [8:0] sa, input logic [8:0] ea, input int n, input int fm,
                        input bit grand);
    int idx = 0;
    int cyc = 0;
    bit acc;
    wq.delete();
    done_cnt     = 0;
    start_i      = 1'b1;
    start_addr_i = sa;
    end_addr_i   = ea;
    @(negedge clk_i);
    start_i = 1'b0;
    while (done_cnt == 0 && cyc < 500) begin
      mem_gnt_i  = grand ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid_i = 1'b0;
      flush_i    = 1'b0;
      in_data_i  = $urandom;
      if (idx < n) begin
        in_valid_i = grand ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data_i  = beats[idx];
        if (fm == 2 && idx == n - 1) flush_i = in_valid_i;
      end else if (fm == 1) begin
        flush_i = 1'b1;
      end
      acc = in_valid_i && in_ready_o;
      @(negedge clk_i);
      cyc++;
      if (acc) idx++;
    end
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    mem_gnt_i  = 1'b0;
    chk("run_completes", 64'(cyc < 500), 64'd1);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_nwrites"}, 64'(wq.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      chk({tag, "_addr"}, 64'(wq[i][72:64]), 64'(exp_q[i][72:64]));
      chk({tag, "_data"}, wq[i][63:0], exp_q[i][63:0]);
    end
    chk({tag, "_words"}, 64'(words_o), 64'(exp_q.size()));
    chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    chk({tag, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  typedef struct {
    logic [8:0]        sa;
    logic [8:0]        ea;
    int                n;
    logic [3:0][31:0]  b;
    int                fm;
    int                exp_n;
    logic [1:0][8:0]   ea_w;
    logic [1:0][63:0]  ed_w;
  } vec_t;

  vec_t vt[5];

  initial begin
    vt[0] = '{9'h010, 9'h011, 4, {32'd4, 32'd3, 32'd2, 32'd1}, 0, 2, {9'h011, 9'h010},
              {64'h00000004_00000003, 64'h00000002_00000001}};
    vt[1] = '{9'h1FF, 9'h000, 4, {32'hD, 32'hC, 32'hB, 32'hA}, 0, 2, {9'h000, 9'h1FF},
              {64'h0000000D_0000000C, 64'h0000000B_0000000A}};
    vt[2] = '{9'h000, 9'h007, 3, {32'd0, 32'd3, 32'd2, 32'd1}, 1, 2, {9'h001, 9'h000},
              {64'h00000000_00000003, 64'h00000002_00000001}};
    vt[3] = '{9'h000, 9'h007, 1, {32'd0, 32'd0, 32'd0, 32'hDEADBEEF}, 2, 1, {9'h000, 9'h000},
              {64'd0, 64'h00000000_DEADBEEF}};
    vt[4] = '{9'h005, 9'h009, 0, {32'd0, 32'd0, 32'd0, 32'd0}, 1, 0, {9'h000, 9'h000},
              {64'd0, 64'd0}};

    // Reset state
    #2;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_wr_en", 64'(wr_en_o), 64'd0);
    chk("rst_ready", 64'(in_ready_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_addr", 64'(wr_addr_o), 64'd0);
    chk("rst_data", wr_data_o, 64'd0);
    chk("rst_words", 64'(words_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed table
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++) beats[i] = vt[v].b[i];
      do_run(vt[v].sa, vt[v].ea, vt[v].n, vt[v].fm, 1'b0);
      exp_q.delete();
      for (int i = 0; i < vt[v].exp_n; i++) exp_q.push_back({vt[v].ea_w[i], vt[v].ed_w[i]});
      check_run($sformatf("vec%0d", v));
    end

    // Grant withheld for 5 cycles: request must hold steady, exactly one write
    wq.delete();
    start_i = 1'b1; start_addr_i = 9'h020; end_addr_i = 9'h020;
    @(negedge clk_i);
    start_i = 1'b0; mem_gnt_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'd5;
    @(negedge clk_i);
    in_data_i = 32'd6;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    chk("hold_latency_wr_en", 64'(wr_en_o), 64'd1);
    for (int c = 0; c < 5; c++) begin
      flush_i = 1'b1;
      chk("hold_wr_en", 64'(wr_en_o), 64'd1);
      chk("hold_addr", 64'(wr_addr_o), 64'h020);
      chk("hold_data", wr_data_o, 64'h00000006_00000005);
      chk("hold_ready", 64'(in_ready_o), 64'd0);
      @(negedge clk_i);
    end
    flush_i = 1'b0;
    chk("hold_no_write", 64'(wq.size()), 64'd0);
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    chk("hold_one_write", 64'(wq.size()), 64'd1);
    chk("hold_done", 64'(done_o), 64'd1);
    chk("hold_words", 64'(words_o), 64'd1);
    @(negedge clk_i);
    chk("hold_done_pulse", 64'(done_o), 64'd0);
    chk("hold_idle", 64'(busy_o), 64'd0);

    // start_i while busy is ignored
    wq.delete();
    start_i = 1'b1; start_addr_i = 9'h030; end_addr_i = 9'h030;
    @(negedge clk_i);
    start_addr_i = 9'h100; end_addr_i = 9'h100; in_valid_i = 1'b1; in_data_i = 32'd7;
    @(negedge clk_i);
    start_i = 1'b0; in_data_i = 32'd8;
    @(negedge clk_i);
    in_valid_i = 1'b0; mem_gnt_i = 1'b1;
    repeat (3) @(negedge clk_i);
    mem_gnt_i = 1'b0;
    chk("busy_start_nwrites", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) begin
      chk("busy_start_addr", 64'(wq[0][72:64]), 64'h030);
      chk("busy_start_data", wq[0][63:0], 64'h00000008_00000007);
    end

    // Asynchronous reset while in BUF_HI
    wq.delete();
    start_i = 1'b1; start_addr_i = 9'h000; end_addr_i = 9'h007;
    @(negedge clk_i);
    start_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'd9;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    chk("prerst_ready", 64'(in_ready_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_ready", 64'(in_ready_o), 64'd0);
    chk("arst_data", wr_data_o, 64'd0);
    chk("arst_words", 64'(words_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1; mem_gnt_i = 1'b1;
    repeat (6) @(negedge clk_i);
    mem_gnt_i = 1'b0;
    chk("arst_no_write", 64'(wq.size()), 64'd0);
    chk("arst_idle", 64'(busy_o), 64'd0);

    // Randomized runs against the reference
    for (int r = 0; r < 40; r++) begin
      int len, fm, n;
      logic [8:0] sa;
      len = $urandom_range(1, 4);
      sa  = (r % 4 == 0) ? 9'(9'h1FD + $urandom_range(0, 2)) : 9'($urandom);
      fm  = $urandom_range(0, 2);
      if (fm == 0) n = 2 * len;
      else n = $urandom_range(fm == 2 ? 1 : 0, 2 * len - 1);
      for (int i = 0; i < 16; i++) beats[i] = $urandom;
      do_run(sa, 9'(sa + 9'(len - 1)), n, fm, 1'b1);
      build_exp(sa, n);
      check_run($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
